// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter with configurable frame format fed by a small input FIFO
// Ports: clk; rst_n async active-low; din/din_vld write port, accepted while rdy (FIFO not full);
//        dout serial line (idle high, registered); busy high while a frame is in progress.
module uart_tx_fifo #(
  parameter int CNT_MAX   = 2604,
  parameter int DATA_W    = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int FIFO_AW   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] din,
  input  logic              din_vld,
  output logic              rdy,
  output logic              dout,
  output logic              busy
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CW = $clog2(CNT_MAX);
  localparam int BW = $clog2(DATA_W);
  localparam bit PAR_EN = PARITY == 1 || PARITY == 2;
  localparam bit ODD = PARITY == 1;
  localparam int NSTOP = STOP_BITS == 2 ? 2 : 1;
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;
  state_t state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0] count;
  logic [CW-1:0] cnt;
  logic [BW-1:0] bit_cnt;
  logic [DATA_W-1:0] sh;
  logic par, push, pop, tick;
  assign rdy = count != (FIFO_AW+1)'(DEPTH);
  assign push = din_vld && rdy;
  assign tick = cnt == CW'(CNT_MAX - 1);
  // popping on the last clock of the final stop bit chains frames with no idle gap
  assign pop = count != '0 && (state == IDLE || (state == STOP && tick && bit_cnt == BW'(NSTOP - 1)));
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= din;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + FIFO_AW'(push);
      rd_ptr <= rd_ptr + FIFO_AW'(pop);
      count <= count + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(pop);
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      bit_cnt <= '0;
      sh <= '0;
      par <= 1'b0;
      dout <= 1'b1;
      busy <= 1'b0;
    end else begin
      cnt <= (state == IDLE || tick) ? '0 : cnt + 1'b1;
      if (pop) begin
        sh <= mem[rd_ptr];
        par <= ODD ^ (^mem[rd_ptr]);
        state <= START;
        bit_cnt <= '0;
        dout <= 1'b0;
        busy <= 1'b1;
      end else if (tick)
        case (state)
          START: begin
            state <= DATA;
            dout <= sh[0];
          end
          DATA:
            if (bit_cnt == BW'(DATA_W - 1)) begin
              state <= PAR_EN ? PAR : STOP;
              dout <= PAR_EN ? par : 1'b1;
              bit_cnt <= '0;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              sh <= sh >> 1;
              dout <= sh[1];
            end
          PAR: begin
            state <= STOP;
            dout <= 1'b1;
          end
          STOP:
            if (bit_cnt == BW'(NSTOP - 1)) begin
              state <= IDLE;
              busy <= 1'b0;
              bit_cnt <= '0;
            end else
              bit_cnt <= bit_cnt + 1'b1;
          default: state <= IDLE;
        endcase
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed and randomized checks of uart_tx_fifo against a frame-level model
module tb_uart_tx_fifo;
  localparam int CNT = 50;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [3:0] vld = '0;
  logic [3:0] dout_o, busy_o, rdy_o;
  logic [3:0][8:0] din_a = '0;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;

  uart_tx_fifo #(.CNT_MAX(CNT)) d0 (.clk(clk), .rst_n(rst_n), .din(din_a[0][7:0]), .din_vld(vld[0]),
    .rdy(rdy_o[0]), .dout(dout_o[0]), .busy(busy_o[0]));
  uart_tx_fifo #(.CNT_MAX(CNT), .PARITY(2)) d1 (.clk(clk), .rst_n(rst_n), .din(din_a[1][7:0]), .din_vld(vld[1]),
    .rdy(rdy_o[1]), .dout(dout_o[1]), .busy(busy_o[1]));
  uart_tx_fifo #(.CNT_MAX(CNT), .PARITY(1)) d2 (.clk(clk), .rst_n(rst_n), .din(din_a[2][7:0]), .din_vld(vld[2]),
    .rdy(rdy_o[2]), .dout(dout_o[2]), .busy(busy_o[2]));
  uart_tx_fifo #(.CNT_MAX(CNT), .DATA_W(7), .STOP_BITS(2)) d3 (.clk(clk), .rst_n(rst_n), .din(din_a[3][6:0]),
    .din_vld(vld[3]), .rdy(rdy_o[3]), .dout(dout_o[3]), .busy(busy_o[3]));

  function automatic int dw(int i); return i == 3 ? 7 : 8; endfunction
  function automatic int pm(int i); return i == 1 ? 2 : i == 2 ? 1 : 0; endfunction
  function automatic int sb(int i); return i == 3 ? 2 : 1; endfunction

  // model: queued words, and the current frame as a list of line levels, each lasting CNT clocks
  logic [8:0] q [4][$];
  bit fr_act [4];
  int fr_off [4], fl [4];
  bit [15:0] fb [4];
  bit acc, fin;

  task automatic build(input int i, input logic [8:0] w);
    int n = 1, ones = 0;
    fb[i] = '0;
    for (int b = 0; b < dw(i); b++) begin fb[i][n] = w[b]; ones += int'(w[b]); n++; end
    if (pm(i) == 1 || pm(i) == 2) begin fb[i][n] = pm(i) == 1 ? (ones % 2 == 0) : (ones % 2 == 1); n++; end
    for (int s = 0; s < sb(i); s++) begin fb[i][n] = 1'b1; n++; end
    fl[i] = n;
  endtask

  always @(posedge clk or negedge rst_n)
    if (!rst_n)
      for (int i = 0; i < 4; i++) begin q[i].delete(); fr_act[i] = 0; fr_off[i] = 0; end
    else
      for (int i = 0; i < 4; i++) begin
        acc = vld[i] && q[i].size() != 4;
        fin = !fr_act[i] || fr_off[i] == fl[i] * CNT - 1;
        if (!fin) fr_off[i]++;
        else if (q[i].size() != 0) begin build(i, q[i].pop_front()); fr_act[i] = 1; fr_off[i] = 0; end
        else fr_act[i] = 0;
        if (acc) q[i].push_back(din_a[i] & ((9'd1 << dw(i)) - 9'd1));
      end

  function automatic logic exp_dout(int i); return fr_act[i] ? fb[i][fr_off[i] / CNT] : 1'b1; endfunction
  function automatic logic exp_busy(int i); return fr_act[i]; endfunction
  function automatic logic exp_rdy(int i); return q[i].size() != 4; endfunction

  task automatic test_reset();
    #12;
    checks += 3;
    if (dout_o !== 4'hF) begin errors++; $display("FAIL reset_dout got %b want 1111", dout_o); end
    if (busy_o !== 4'h0) begin errors++; $display("FAIL reset_busy got %b want 0000", busy_o); end
    if (rdy_o !== 4'hF) begin errors++; $display("FAIL reset_rdy got %b want 1111", rdy_o); end
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) begin
        checks += 3;
        if (dout_o[i] !== exp_dout(i)) begin errors++; $display("FAIL idle_dout[%0d] got %b want %b", i, dout_o[i], exp_dout(i)); end
        if (busy_o[i] !== exp_busy(i)) begin errors++; $display("FAIL idle_busy[%0d] got %b want %b", i, busy_o[i], exp_busy(i)); end
        if (rdy_o[i] !== exp_rdy(i)) begin errors++; $display("FAIL idle_rdy[%0d] got %b want %b", i, rdy_o[i], exp_rdy(i)); end
      end
    end
  endtask

  task automatic test_8n1();
    logic [9:0] fr = {1'b1, 8'hA5, 1'b0};
    int nb = 0;
    @(posedge clk); #1 din_a[0] = 9'h0A5; vld[0] = 1'b1;
    @(posedge clk); #1 vld[0] = 1'b0;
    for (int k = 0; k < 520; k++) begin
      for (int i = 0; i < 4; i++) begin
        checks += 3;
        if (dout_o[i] !== exp_dout(i)) begin errors++; $display("FAIL 8n1_dout[%0d] k=%0d got %b want %b", i, k, dout_o[i], exp_dout(i)); end
        if (busy_o[i] !== exp_busy(i)) begin errors++; $display("FAIL 8n1_busy[%0d] k=%0d got %b want %b", i, k, busy_o[i], exp_busy(i)); end
        if (rdy_o[i] !== exp_rdy(i)) begin errors++; $display("FAIL 8n1_rdy[%0d] k=%0d got %b want %b", i, k, rdy_o[i], exp_rdy(i)); end
      end
      nb += int'(busy_o[0]);
      if (k < 2) begin
        checks++;
        if (busy_o[0] !== (k == 1)) begin errors++; $display("FAIL 8n1_latency k=%0d busy got %b want %b", k, busy_o[0], k == 1); end
      end
      if (k >= 1 && k <= 500 && (k - 1) % CNT == 25) begin
        checks++;
        if (dout_o[0] !== fr[(k - 1) / CNT]) begin errors++; $display("FAIL 8n1_bit%0d got %b want %b", (k - 1) / CNT, dout_o[0], fr[(k - 1) / CNT]); end
      end
      @(posedge clk); #1;
    end
    checks++;
    if (nb != 500) begin errors++; $display("FAIL 8n1_busy_len got %0d want 500", nb); end
  endtask

  task automatic test_parity();
    int nb1 = 0, nb2 = 0;
    @(posedge clk); #1 din_a[1] = 9'h0A5; din_a[2] = 9'h0A5; vld[1] = 1'b1; vld[2] = 1'b1;
    @(posedge clk); #1 vld[1] = 1'b0; vld[2] = 1'b0;
    for (int k = 0; k < 570; k++) begin
      for (int i = 0; i < 4; i++) begin
        checks += 3;
        if (dout_o[i] !== exp_dout(i)) begin errors++; $display("FAIL par_dout[%0d] k=%0d got %b want %b", i, k, dout_o[i], exp_dout(i)); end
        if (busy_o[i] !== exp_busy(i)) begin errors++; $display("FAIL par_busy[%0d] k=%0d got %b want %b", i, k, busy_o[i], exp_busy(i)); end
        if (rdy_o[i] !== exp_rdy(i)) begin errors++; $display("FAIL par_rdy[%0d] k=%0d got %b want %b", i, k, rdy_o[i], exp_rdy(i)); end
      end
      nb1 += int'(busy_o[1]);
      nb2 += int'(busy_o[2]);
      if (k == 476) begin
        checks += 2;
        if (dout_o[1] !== 1'b0) begin errors++; $display("FAIL even_parity_bit got %b want 0", dout_o[1]); end
        if (dout_o[2] !== 1'b1) begin errors++; $display("FAIL odd_parity_bit got %b want 1", dout_o[2]); end
      end
      @(posedge clk); #1;
    end
    checks += 2;
    if (nb1 != 550) begin errors++; $display("FAIL even_frame_len got %0d want 550", nb1); end
    if (nb2 != 550) begin errors++; $display("FAIL odd_frame_len got %0d want 550", nb2); end
  endtask

  task automatic test_7n2();
    logic [9:0] fr = {2'b11, 7'h41, 1'b0};
    int nb = 0;
    @(posedge clk); #1 din_a[3] = 9'h041; vld[3] = 1'b1;
    @(posedge clk); #1 vld[3] = 1'b0;
    for (int k = 0; k < 520; k++) begin
      for (int i = 0; i < 4; i++) begin
        checks += 3;
        if (dout_o[i] !== exp_dout(i)) begin errors++; $display("FAIL 7n2_dout[%0d] k=%0d got %b want %b", i, k, dout_o[i], exp_dout(i)); end
        if (busy_o[i] !== exp_busy(i)) begin errors++; $display("FAIL 7n2_busy[%0d] k=%0d got %b want %b", i, k, busy_o[i], exp_busy(i)); end
        if (rdy_o[i] !== exp_rdy(i)) begin errors++; $display("FAIL 7n2_rdy[%0d] k=%0d got %b want %b", i, k, rdy_o[i], exp_rdy(i)); end
      end
      nb += int'(busy_o[3]);
      if (k >= 1 && k <= 500 && (k - 1) % CNT == 25) begin
        checks++;
        if (dout_o[3] !== fr[(k - 1) / CNT]) begin errors++; $display("FAIL 7n2_bit%0d got %b want %b", (k - 1) / CNT, dout_o[3], fr[(k - 1) / CNT]); end
      end
      @(posedge clk); #1;
    end
    checks++;
    if (nb != 500) begin errors++; $display("FAIL 7n2_frame_len got %0d want 500", nb); end
  endtask

  task automatic test_back_to_back();
    int nb = 0;
    @(posedge clk); #1 din_a[0] = 9'h001; vld[0] = 1'b1;
    for (int k = 0; k < 2560; k++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) begin
        checks += 3;
        if (dout_o[i] !== exp_dout(i)) begin errors++; $display("FAIL b2b_dout[%0d] k=%0d got %b want %b", i, k, dout_o[i], exp_dout(i)); end
        if (busy_o[i] !== exp_busy(i)) begin errors++; $display("FAIL b2b_busy[%0d] k=%0d got %b want %b", i, k, busy_o[i], exp_busy(i)); end
        if (rdy_o[i] !== exp_rdy(i)) begin errors++; $display("FAIL b2b_rdy[%0d] k=%0d got %b want %b", i, k, rdy_o[i], exp_rdy(i)); end
      end
      nb += int'(busy_o[0]);
      if (k == 4 || k == 5 || k == 20 || k == 500 || k == 501) begin
        checks++;
        if (rdy_o[0] !== (k == 501)) begin errors++; $display("FAIL b2b_rdy_edge k=%0d got %b want %b", k, rdy_o[0], k == 501); end
      end
      vld[0] = k < 5 || k == 19;
      din_a[0] = k == 19 ? 9'h077 : 9'(k + 2);
    end
    checks++;
    if (nb != 2500) begin errors++; $display("FAIL b2b_busy_total got %0d want 2500", nb); end
  endtask

  task automatic test_reset_mid();
    int nb = 0, nlow = 0;
    @(posedge clk); #1 din_a[0] = 9'h011; vld[0] = 1'b1;
    @(posedge clk); #1 din_a[0] = 9'h022;
    @(posedge clk); #1 din_a[0] = 9'h033;
    @(posedge clk); #1 vld[0] = 1'b0;
    repeat (200) begin
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) begin
        checks += 3;
        if (dout_o[i] !== exp_dout(i)) begin errors++; $display("FAIL pre_rst_dout[%0d] got %b want %b", i, dout_o[i], exp_dout(i)); end
        if (busy_o[i] !== exp_busy(i)) begin errors++; $display("FAIL pre_rst_busy[%0d] got %b want %b", i, busy_o[i], exp_busy(i)); end
        if (rdy_o[i] !== exp_rdy(i)) begin errors++; $display("FAIL pre_rst_rdy[%0d] got %b want %b", i, rdy_o[i], exp_rdy(i)); end
      end
    end
    #3 rst_n = 1'b0;
    #1;
    checks += 3;
    if (dout_o[0] !== 1'b1) begin errors++; $display("FAIL mid_rst_dout got %b want 1", dout_o[0]); end
    if (busy_o[0] !== 1'b0) begin errors++; $display("FAIL mid_rst_busy got %b want 0", busy_o[0]); end
    if (rdy_o[0] !== 1'b1) begin errors++; $display("FAIL mid_rst_rdy got %b want 1", rdy_o[0]); end
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (600) begin
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) begin
        checks += 3;
        if (dout_o[i] !== exp_dout(i)) begin errors++; $display("FAIL post_rst_dout[%0d] got %b want %b", i, dout_o[i], exp_dout(i)); end
        if (busy_o[i] !== exp_busy(i)) begin errors++; $display("FAIL post_rst_busy[%0d] got %b want %b", i, busy_o[i], exp_busy(i)); end
        if (rdy_o[i] !== exp_rdy(i)) begin errors++; $display("FAIL post_rst_rdy[%0d] got %b want %b", i, rdy_o[i], exp_rdy(i)); end
      end
      nb += int'(busy_o[0]);
      nlow += int'(!dout_o[0]);
    end
    checks += 2;
    if (nb != 0) begin errors++; $display("FAIL post_rst_busy_cycles got %0d want 0", nb); end
    if (nlow != 0) begin errors++; $display("FAIL post_rst_low_cycles got %0d want 0", nlow); end
    din_a[0] = 9'h055; vld[0] = 1'b1;
    @(posedge clk); #1 vld[0] = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (busy_o[0] !== 1'b1 || dout_o[0] !== 1'b0) begin errors++; $display("FAIL post_rst_new_frame busy=%b dout=%b want busy=1 dout=0", busy_o[0], dout_o[0]); end
    repeat (520) begin
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) begin
        checks += 3;
        if (dout_o[i] !== exp_dout(i)) begin errors++; $display("FAIL new_frame_dout[%0d] got %b want %b", i, dout_o[i], exp_dout(i)); end
        if (busy_o[i] !== exp_busy(i)) begin errors++; $display("FAIL new_frame_busy[%0d] got %b want %b", i, busy_o[i], exp_busy(i)); end
        if (rdy_o[i] !== exp_rdy(i)) begin errors++; $display("FAIL new_frame_rdy[%0d] got %b want %b", i, rdy_o[i], exp_rdy(i)); end
      end
    end
  endtask

  task automatic test_random();
    int sent [4] = '{default: 0};
    bit done = 1'b0;
    int k = 0;
    while (!done && k < 12000) begin
      for (int i = 0; i < 4; i++) begin
        vld[i] = sent[i] < 10 && $urandom_range(0, 2) == 0;
        din_a[i] = 9'($urandom);
        sent[i] += int'(vld[i] && exp_rdy(i));
      end
      @(posedge clk); #1;
      k++;
      for (int i = 0; i < 4; i++) begin
        checks += 3;
        if (dout_o[i] !== exp_dout(i)) begin errors++; $display("FAIL rnd_dout[%0d] k=%0d got %b want %b", i, k, dout_o[i], exp_dout(i)); end
        if (busy_o[i] !== exp_busy(i)) begin errors++; $display("FAIL rnd_busy[%0d] k=%0d got %b want %b", i, k, busy_o[i], exp_busy(i)); end
        if (rdy_o[i] !== exp_rdy(i)) begin errors++; $display("FAIL rnd_rdy[%0d] k=%0d got %b want %b", i, k, rdy_o[i], exp_rdy(i)); end
      end
      done = 1'b1;
      for (int i = 0; i < 4; i++)
        if (sent[i] < 10 || q[i].size() != 0 || fr_act[i]) done = 1'b0;
    end
    vld = '0;
    checks++;
    if (!done) begin errors++; $display("FAIL rnd_timeout after %0d cycles, drained=%b want 1", k, done); end
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_parity();
    test_7n2();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
